// File: rtl/ptp_clock_cdc_single.sv
// Single-clock PTP time-of-day follower: free-runs at a programmable period and
// disciplines phase/frequency to sporadic reference samples, stepping on large error.
module ptp_clock_cdc_single #(
    parameter int unsigned          TS_WIDTH       = 96,
    parameter int unsigned          NS_WIDTH       = 4,
    parameter int unsigned          FNS_WIDTH      = 16,
    parameter logic [NS_WIDTH-1:0]  PERIOD_NS      = 4'h6,
    parameter logic [FNS_WIDTH-1:0] PERIOD_FNS     = 16'h6666,
    parameter int unsigned          LOG_RATE       = 3,
    parameter int unsigned          STEP_THRESH_NS = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TS_WIDTH-1:0] input_ts,
    input  logic                input_ts_valid,
    output logic [TS_WIDTH-1:0] output_ts,
    output logic                output_ts_step,
    output logic                output_pps
);

    localparam int unsigned  PW         = NS_WIDTH + FNS_WIDTH + 16;
    localparam logic [PW-1:0] NOMINAL    = {PERIOD_NS, PERIOD_FNS, 16'h0000};
    localparam logic [PW-1:0] PERIOD_MAX = NOMINAL + (NOMINAL >> 2);
    localparam logic [PW-1:0] PERIOD_MIN = NOMINAL - (NOMINAL >> 2);
    localparam logic [63:0]   THRESH     = 64'(STEP_THRESH_NS) << 16;

    logic [PW-1:0]      period_q, period_d;
    logic               init_q, step_q, pps_q;
    logic signed [63:0] diff, diff_abs, inc, inc_ns, period_adj, period_sum;
    logic               force_step, step, track, wrap_up;

    always_comb begin
        diff_abs   = diff[63] ? -diff : diff;
        step       = input_ts_valid && (init_q || force_step || ($unsigned(diff_abs) >= THRESH));
        track      = input_ts_valid && !step;
        inc_ns     = $signed(64'(period_q[PW-1:16])) + (diff >>> LOG_RATE);
        period_adj = (diff <<< 16) >>> (2 * LOG_RATE);
        period_sum = $signed(64'(period_q)) + period_adj;
        if (step) begin
            inc      = $signed(64'(NOMINAL));
            period_d = NOMINAL;
        end else if (track) begin
            // Phase correction uses whole fns only; the hidden fraction is left untouched.
            inc = inc_ns <<< 16;
            if (period_sum > $signed(64'(PERIOD_MAX))) begin
                period_d = PERIOD_MAX;
            end else if (period_sum < $signed(64'(PERIOD_MIN))) begin
                period_d = PERIOD_MIN;
            end else begin
                period_d = PW'(period_sum);
            end
        end else begin
            inc      = $signed(64'(period_q));
            period_d = period_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_q <= NOMINAL;
            init_q   <= 1'b1;
            step_q   <= 1'b0;
            pps_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            init_q   <= init_q && !step;
            step_q   <= step;
            pps_q    <= wrap_up && !step;
        end
    end

    assign output_ts_step = step_q;
    assign output_pps     = pps_q;

    if (TS_WIDTH == 96) begin : g_tod
        localparam logic signed [63:0] NS_SEC_FNS = 64'sd65536000000000;
        localparam logic signed [63:0] ONE_SEC    = 64'sd4294967296000000000;

        logic [47:0]        sec_q, sec_d, sec_diff, base_sec;
        logic [63:0]        frac_q, frac_d, base_frac;
        logic signed [63:0] nf_diff, sum;

        always_comb begin
            sec_diff   = input_ts[95:48] - sec_q;
            nf_diff    = $signed({16'h0000, input_ts[47:0]}) - $signed({16'h0000, frac_q[63:16]});
            force_step = 1'b0;
            diff       = nf_diff;
            if (sec_diff == 48'd1) begin
                diff = nf_diff + NS_SEC_FNS;
            end else if (sec_diff == '1) begin
                diff = nf_diff - NS_SEC_FNS;
            end else if (sec_diff != '0) begin
                force_step = 1'b1;
            end
        end

        always_comb begin
            base_sec  = step ? input_ts[95:48] : sec_q;
            base_frac = step ? {input_ts[47:0], 16'h0000} : frac_q;
            sum       = $signed(base_frac) + inc;
            wrap_up   = 1'b0;
            sec_d     = base_sec;
            frac_d    = sum;
            if (sum >= ONE_SEC) begin
                frac_d  = sum - ONE_SEC;
                sec_d   = base_sec + 48'd1;
                wrap_up = 1'b1;
            end else if (sum < 0) begin
                // A large negative phase correction borrows from the seconds field.
                frac_d = sum + ONE_SEC;
                sec_d  = base_sec - 48'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sec_q  <= '0;
                frac_q <= '0;
            end else begin
                sec_q  <= sec_d;
                frac_q <= frac_d;
            end
        end

        assign output_ts = {sec_q, frac_q[63:16]};
    end else begin : g_free
        logic [79:0] acc_q, acc_d;

        always_comb begin
            force_step = 1'b0;
            diff       = $signed(input_ts - acc_q[79:16]);
        end

        always_comb begin
            wrap_up = 1'b0;
            acc_d   = (step ? {input_ts, 16'h0000} : acc_q) + 80'(inc);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        assign output_ts = acc_q[79:16];
    end

endmodule

// File: tb/tb_ptp_clock_cdc_single.sv
// Randomized bench for ptp_clock_cdc_single against a longint time/period model.
module tb_ptp_clock_cdc_single;

    localparam longint NSF     = 64'd65536000000000;
    localparam longint ONE_SEC = 64'd4294967296000000000;
    localparam longint NOM     = 64'h6_6666_0000;
    localparam longint PMAX    = NOM + NOM / 4;
    localparam longint PMIN    = NOM - NOM / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] input_ts = '0;
    logic        input_ts_valid = 1'b0;
    logic [95:0] output_ts;
    logic        output_ts_step;
    logic        output_pps;

    int n_vec = 0;
    int n_err = 0;

    longint m_sec, m_frac, m_period;
    bit     m_init, m_step, m_pps;

    always #5 clk = ~clk;

    ptp_clock_cdc_single dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .input_ts       (input_ts),
        .input_ts_valid (input_ts_valid),
        .output_ts      (output_ts),
        .output_ts_step (output_ts_step),
        .output_pps     (output_pps)
    );

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input longint s, input longint ns, input longint fns);
        logic [47:0] s48;
        logic [31:0] ns32;
        logic [15:0] f16;
        s48  = s[47:0];
        ns32 = ns[31:0];
        f16  = fns[15:0];
        return {s48, ns32, f16};
    endfunction

    function automatic logic [95:0] model_ts();
        longint nf;
        logic [47:0] s48;
        logic [47:0] nf48;
        nf   = m_frac >>> 16;
        s48  = m_sec[47:0];
        nf48 = nf[47:0];
        return {s48, nf48};
    endfunction

    // Reference time shifted by off_fns from the model's current time.
    function automatic logic [95:0] near(input longint off_fns);
        longint total, s, r;
        total = m_sec * NSF + (m_frac >>> 16) + off_fns;
        s     = total / NSF;
        r     = total % NSF;
        return mk(s, r >>> 16, r & 64'hFFFF);
    endfunction

    task automatic model_edge(input bit rst, input bit vld, input logic [95:0] ts);
        longint in_sec, in_nf, sd, diff, adiff, p;
        bit st, up;
        if (!rst) begin
            m_sec = 0; m_frac = 0; m_period = NOM; m_init = 1; m_step = 0; m_pps = 0;
            return;
        end
        in_sec = longint'(ts[95:48]);
        in_nf  = longint'(ts[47:0]);
        sd     = in_sec - m_sec;
        diff   = in_nf - (m_frac >>> 16) + sd * NSF;
        adiff  = (diff < 0) ? -diff : diff;
        st     = vld && (m_init || sd > 1 || sd < -1 || adiff >= 1000 * 65536);
        if (st) begin
            m_sec = in_sec; m_frac = (in_nf * 65536) + NOM; m_period = NOM; m_init = 0;
        end else if (vld) begin
            m_frac = m_frac + ((m_period >>> 16) + (diff >>> 3)) * 65536;
            p = m_period + ((diff * 65536) >>> 6);
            if (p > PMAX) p = PMAX;
            if (p < PMIN) p = PMIN;
            m_period = p;
        end else begin
            m_frac = m_frac + m_period;
        end
        up = 0;
        if (m_frac >= ONE_SEC) begin
            m_frac = m_frac - ONE_SEC; m_sec = m_sec + 1; up = 1;
        end else if (m_frac < 0) begin
            m_frac = m_frac + ONE_SEC; m_sec = m_sec - 1;
        end
        m_step = st;
        m_pps  = up && !st;
    endtask

    task automatic cyc(input bit vld, input logic [95:0] ts, input string tag);
        input_ts       = ts;
        input_ts_valid = vld;
        model_edge(rst_n, vld, ts);
        @(posedge clk);
        @(negedge clk);
        input_ts_valid = 1'b0;
        check_val({tag, "_ts"}, output_ts, model_ts());
        check_val({tag, "_step"}, 96'(output_ts_step), 96'(m_step));
        check_val({tag, "_pps"}, 96'(output_pps), 96'(m_pps));
    endtask

    initial begin
        int r;
        longint off;
        rst_n = 1'b0;
        cyc(0, '0, "rst");
        cyc(0, '0, "rst");
        rst_n = 1'b1;
        repeat (10) cyc(0, '0, "idle");
        check_val("idle10_const", output_ts, mk(0, 63, 16'hFFFC));

        cyc(1, mk(5, 1000, 0), "first");
        check_val("first_const", output_ts, mk(5, 1006, 16'h6666));
        check_val("first_step", 96'(output_ts_step), 96'd1);
        cyc(0, '0, "first_after");

        cyc(1, mk(7, 999_999_990, 0), "preroll");
        check_val("preroll_pps", 96'(output_pps), 96'd0);
        cyc(0, '0, "roll");
        check_val("roll_const", output_ts, mk(8, 2, 16'hCCCC));
        check_val("roll_pps", 96'(output_pps), 96'd1);

        cyc(1, mk(10, 100, 0), "step10");
        cyc(1, mk(10, 186, 16'h6666), "track80");
        check_val("track80_const", output_ts, mk(10, 122, 16'hCCCC));
        check_val("track80_step", 96'(output_ts_step), 96'd0);
        cyc(0, '0, "track80_idle");
        check_val("track80_idle_const", output_ts, mk(10, 130, 16'h7332));

        cyc(1, near(longint'(1001) * 65536), "plus1001");
        check_val("plus1001_step", 96'(output_ts_step), 96'd1);
        cyc(1, near(-longint'(999) * 65536), "minus999");
        check_val("minus999_step", 96'(output_ts_step), 96'd0);
        repeat (6) cyc(1, near(longint'(990) * 65536), "clamp");
        repeat (4) cyc(0, '0, "clamp_idle");

        rst_n = 1'b0;
        cyc(0, '0, "midrst");
        check_val("midrst_const", output_ts, 96'd0);
        rst_n = 1'b1;
        cyc(1, mk(20, 5, 0), "post_rst");
        check_val("post_rst_step", 96'(output_ts_step), 96'd1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst_n = 1'b0;
                cyc(0, '0, "rnd_rst");
                rst_n = 1'b1;
            end else if (r < 50) begin
                cyc(0, '0, "rnd_idle");
            end else if (m_init || r < 54) begin
                cyc(1, mk($urandom_range(50, 150), $urandom_range(0, 999_999_999),
                          $urandom_range(0, 65535)), "rnd_far");
            end else if (r < 58) begin
                cyc(1, mk($urandom_range(50, 150), 999_999_900 + $urandom_range(0, 99),
                          $urandom_range(0, 65535)), "rnd_edge");
            end else begin
                off = longint'($urandom_range(0, 2 * 1100 * 65536)) - longint'(1100 * 65536);
                cyc(1, near(off), "rnd_near");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
